// File: rtl/operand_fetch_pkg.sv
// Shared CPU constants for the operand-fetch stage.
// Holds default widths, the x0 address and the operand count.
package operand_fetch_pkg;
  localparam int XLEN_DEF      = 32;
  localparam int REGADDR_W_DEF = 5;
  localparam int X0_ADDR       = 0;
  localparam int NUM_OPS       = 2;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side handshakes of the operand-fetch stage.
// The slave modport is the stage; the master modport is its surroundings.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF
);
  logic                 in_valid;
  logic                 in_ready;
  logic [REGADDR_W-1:0] in_rs1;
  logic [REGADDR_W-1:0] in_rs2;
  logic [REGADDR_W-1:0] in_rd;
  logic [XLEN-1:0]      in_pc;
  logic                 in_regwr;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_op1;
  logic [XLEN-1:0]      out_op2;
  logic [REGADDR_W-1:0] out_rd;
  logic [XLEN-1:0]      out_pc;
  logic                 out_regwr;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_pc, in_regwr, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_rd, out_pc, out_regwr
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_pc, in_regwr, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_rd, out_pc, out_regwr
  );
endinterface

// File: rtl/operand_bypass.sv
// Selects one source operand: x0 reads zero, a same-cycle write-back wins
// over the register-file read, otherwise the register-file data is used.
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF
) (
  input  logic [REGADDR_W-1:0] rs,
  input  logic [XLEN-1:0]      rf_data,
  input  logic [REGADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 wb_regwr,
  output logic [XLEN-1:0]      op
);
  always_comb begin
    op = rf_data;
    if (rs == REGADDR_W'(X0_ADDR))          op = '0;
    else if (wb_regwr && (wb_rd == rs))     op = wb_data;
  end
endmodule

// File: rtl/operand_fetch.sv
// Single-entry operand-fetch stage: reads the register file, bypasses the
// write port, and keeps held operands coherent with later write-backs.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REGADDR_W = REGADDR_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  operand_fetch_if.slave       pipe,
  output logic [REGADDR_W-1:0] RS1,
  output logic [REGADDR_W-1:0] RS2,
  input  logic [XLEN-1:0]      RD1,
  input  logic [XLEN-1:0]      RD2,
  input  logic [REGADDR_W-1:0] WbRD,
  input  logic [XLEN-1:0]      WbData,
  input  logic                 WbRegWr,
  input  logic                 flush
);
  logic [NUM_OPS-1:0][REGADDR_W-1:0] src_rs;
  logic [NUM_OPS-1:0][REGADDR_W-1:0] held_rs;
  logic [NUM_OPS-1:0][XLEN-1:0]      rf_rd;
  logic [NUM_OPS-1:0][XLEN-1:0]      fwd_op;
  logic [NUM_OPS-1:0][XLEN-1:0]      held_op;
  logic [NUM_OPS-1:0]                hold_hit;

  logic                 vld_q;
  logic [XLEN-1:0]      pc_q;
  logic [REGADDR_W-1:0] rd_q;
  logic                 regwr_q;
  logic                 accept;
  logic                 hold;

  assign RS1    = pipe.in_rs1;
  assign RS2    = pipe.in_rs2;
  assign src_rs = {pipe.in_rs2, pipe.in_rs1};
  assign rf_rd  = {RD2, RD1};

  assign pipe.in_ready = !vld_q || pipe.out_ready;
  assign accept        = pipe.in_valid && pipe.in_ready;
  assign hold          = vld_q && !pipe.out_ready;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    operand_bypass #(
      .XLEN      (XLEN),
      .REGADDR_W (REGADDR_W)
    ) u_bypass (
      .rs       (src_rs[g]),
      .rf_data  (rf_rd[g]),
      .wb_rd    (WbRD),
      .wb_data  (WbData),
      .wb_regwr (WbRegWr),
      .op       (fwd_op[g])
    );

    // A held operand must track writes to its source, or it goes stale.
    assign hold_hit[g] = WbRegWr && (WbRD != REGADDR_W'(X0_ADDR)) &&
                         (WbRD == held_rs[g]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_q   <= 1'b0;
      held_op <= '0;
      held_rs <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      regwr_q <= 1'b0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (accept) begin
      vld_q   <= 1'b1;
      held_op <= fwd_op;
      held_rs <= src_rs;
      pc_q    <= pipe.in_pc;
      rd_q    <= pipe.in_rd;
      regwr_q <= pipe.in_regwr;
    end else if (hold) begin
      for (int i = 0; i < NUM_OPS; i++)
        if (hold_hit[i]) held_op[i] <= WbData;
    end else begin
      // Drained with nothing new; payload is left in place.
      vld_q <= 1'b0;
    end
  end

  assign pipe.out_valid = vld_q;
  assign pipe.out_op1   = held_op[0];
  assign pipe.out_op2   = held_op[1];
  assign pipe.out_pc    = pc_q;
  assign pipe.out_rd    = rd_q;
  assign pipe.out_regwr = regwr_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed table, hand-written corner sequences and
// a random run checked against a register-file-coherence model.
module tb_operand_fetch;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  RS1, RS2, WbRD;
  logic [31:0] RD1, RD2, WbData;
  logic        WbRegWr, flush;
  logic [31:0] rf [32];

  operand_fetch_if #(.XLEN(32), .REGADDR_W(5)) ifc ();

  operand_fetch #(.XLEN(32), .REGADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .pipe(ifc),
    .RS1(RS1), .RS2(RS2), .RD1(RD1), .RD2(RD2),
    .WbRD(WbRD), .WbData(WbData), .WbRegWr(WbRegWr), .flush(flush)
  );

  always #5 Clk = ~Clk;

  assign RD1 = (RS1 == 5'd0) ? 32'd0 : rf[RS1];
  assign RD2 = (RS2 == 5'd0) ? 32'd0 : rf[RS2];

  int n_chk = 0;
  int n_pass = 0;

  // Model state: what the stage should be presenting.
  logic        model_on = 1'b0;
  logic        m_valid;
  logic [31:0] m_op1, m_op2, m_pc;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_regwr;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdat, e1, e2;
  } vec_t;
  vec_t tbl [6];

  function automatic logic [31:0] rv(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : rf[a];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // One clock edge; afterwards the bench register file and model advance.
  task automatic step();
    logic pre, acc;
    @(posedge Clk);
    #1;
    pre = m_valid;
    acc = ifc.in_valid && (!pre || ifc.out_ready);
    if (WbRegWr && WbRD != 5'd0) rf[WbRD] = WbData;
    if (model_on) begin
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1;
        m_pc = ifc.in_pc; m_rd = ifc.in_rd; m_regwr = ifc.in_regwr;
        m_rs1 = ifc.in_rs1; m_rs2 = ifc.in_rs2;
      end else if (pre && !ifc.out_ready) m_valid = 1'b1;
      else m_valid = 1'b0;
      // A valid held operand always equals the live architectural value.
      if (m_valid) begin
        m_op1 = rv(m_rs1);
        m_op2 = rv(m_rs2);
      end
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_op1 = 0; m_op2 = 0; m_pc = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_regwr = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(ifc.out_valid), 64'd0);
    chk({tag, "_op1"},   64'(ifc.out_op1),   64'd0);
    chk({tag, "_op2"},   64'(ifc.out_op2),   64'd0);
    chk({tag, "_pc"},    64'(ifc.out_pc),    64'd0);
    chk({tag, "_rd"},    64'(ifc.out_rd),    64'd0);
    chk({tag, "_regwr"}, 64'(ifc.out_regwr), 64'd0);
  endtask

  initial begin
    model_clear();
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 0; rf[5] = 32'h1234; rf[7] = 32'h1;
    Reset = 1; flush = 0; WbRegWr = 0; WbRD = 0; WbData = 0;
    ifc.in_valid = 0; ifc.in_rs1 = 0; ifc.in_rs2 = 0; ifc.in_rd = 0;
    ifc.in_pc = 0; ifc.in_regwr = 0; ifc.out_ready = 1;

    tbl[0] = '{5'd5,  5'd0,  1'b0, 5'd0,  32'h0,        32'h1234, 32'h0};
    tbl[1] = '{5'd7,  5'd5,  1'b1, 5'd7,  32'hBEEF,     32'hBEEF, 32'h1234};
    tbl[2] = '{5'd9,  5'd0,  1'b1, 5'd0,  32'hFFFF,     32'h1009, 32'h0};
    tbl[3] = '{5'd3,  5'd3,  1'b1, 5'd3,  32'hA5A5,     32'hA5A5, 32'hA5A5};
    tbl[4] = '{5'd7,  5'd3,  1'b0, 5'd0,  32'h0,        32'hBEEF, 32'hA5A5};
    tbl[5] = '{5'd31, 5'd30, 1'b1, 5'd30, 32'hDEAD0000, 32'h101F, 32'hDEAD0000};

    #12;
    chk_zero("reset");
    chk("reset_in_ready", 64'(ifc.in_ready), 64'd1);
    Reset = 0;
    @(posedge Clk); #1;

    // Table: single-cycle captures with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      ifc.in_valid = 1; ifc.in_rs1 = tbl[i].rs1; ifc.in_rs2 = tbl[i].rs2;
      ifc.in_rd = 5'(i); ifc.in_pc = 32'h100 + 32'(i * 4); ifc.in_regwr = 1;
      ifc.out_ready = 1;
      WbRegWr = tbl[i].wen; WbRD = tbl[i].wrd; WbData = tbl[i].wdat;
      #1;
      chk($sformatf("tbl%0d_RS1", i), 64'(RS1), 64'(tbl[i].rs1));
      step();
      chk($sformatf("tbl%0d_valid", i), 64'(ifc.out_valid), 64'd1);
      chk($sformatf("tbl%0d_op1", i),   64'(ifc.out_op1), 64'(tbl[i].e1));
      chk($sformatf("tbl%0d_op2", i),   64'(ifc.out_op2), 64'(tbl[i].e2));
      chk($sformatf("tbl%0d_pc", i),    64'(ifc.out_pc), 64'(32'h100 + 32'(i * 4)));
    end

    // Drain: valid falls, payload stays.
    ifc.in_valid = 0; WbRegWr = 0;
    step();
    chk("drain_valid", 64'(ifc.out_valid), 64'd0);
    chk("drain_pc",    64'(ifc.out_pc),    64'h114);
    chk("drain_op2",   64'(ifc.out_op2),   64'hDEAD0000);

    // Stall with write-back to the held source.
    ifc.in_valid = 1; ifc.in_rs1 = 3; ifc.in_rs2 = 9; ifc.in_pc = 32'h400;
    ifc.out_ready = 0;
    step();
    chk("stall_cap_op1", 64'(ifc.out_op1), 64'hA5A5);
    ifc.in_pc = 32'h500; ifc.in_rs1 = 1;
    WbRegWr = 1; WbRD = 3; WbData = 32'h55;
    step();
    chk("stall_upd_op1",  64'(ifc.out_op1),  64'h55);
    chk("stall_keep_op2", 64'(ifc.out_op2),  64'h1009);
    chk("stall_pc",       64'(ifc.out_pc),   64'h400);
    chk("stall_valid",    64'(ifc.out_valid), 64'd1);
    chk("stall_in_ready", 64'(ifc.in_ready), 64'd0);

    // Both operands name the same register while held.
    WbRegWr = 0; ifc.out_ready = 1; ifc.in_rs1 = 4; ifc.in_rs2 = 4; ifc.in_pc = 32'h600;
    step();
    chk("same_cap_op1", 64'(ifc.out_op1), 64'h1004);
    ifc.out_ready = 0; ifc.in_valid = 0;
    WbRegWr = 1; WbRD = 4; WbData = 32'h77;
    step();
    chk("same_upd_op1", 64'(ifc.out_op1), 64'h77);
    chk("same_upd_op2", 64'(ifc.out_op2), 64'h77);
    // x0 write while held must not touch anything.
    WbRD = 0; WbData = 32'hFFFF;
    step();
    chk("x0hold_op1", 64'(ifc.out_op1), 64'h77);

    // Flush wins over a simultaneous capture.
    WbRegWr = 0; ifc.out_ready = 1; ifc.in_valid = 1; ifc.in_pc = 32'h700; flush = 1;
    step();
    flush = 0; ifc.in_valid = 0;
    #1;
    chk("flush_valid",    64'(ifc.out_valid), 64'd0);
    chk("flush_in_ready", 64'(ifc.in_ready),  64'd1);
    chk("flush_pc",       64'(ifc.out_pc),    64'h600);

    // Asynchronous reset while stalled.
    ifc.in_valid = 1; ifc.in_rs1 = 5; ifc.in_rs2 = 0; ifc.in_pc = 32'h800;
    step();
    ifc.out_ready = 0; ifc.in_valid = 0;
    #1;
    Reset = 1;
    #1;
    chk_zero("async_rst");
    Reset = 0;
    ifc.in_valid = 1; ifc.in_pc = 32'h900; ifc.out_ready = 1;
    step();
    chk("resume_valid", 64'(ifc.out_valid), 64'd1);
    chk("resume_pc",    64'(ifc.out_pc),    64'h900);
    chk("resume_op1",   64'(ifc.out_op1),   64'h1234);

    // Random run against the coherence model, from a clean reset.
    ifc.in_valid = 0;
    #1 Reset = 1;
    #1 Reset = 0;
    model_clear();
    model_on = 1;
    for (int c = 0; c < 400; c++) begin
      ifc.in_valid  = 1'($urandom);
      ifc.in_rs1    = 5'($urandom_range(0, 7));
      ifc.in_rs2    = 5'($urandom_range(0, 7));
      ifc.in_rd     = 5'($urandom);
      ifc.in_pc     = $urandom;
      ifc.in_regwr  = 1'($urandom);
      ifc.out_ready = ($urandom % 4) != 0;
      WbRegWr       = 1'($urandom);
      WbRD          = 5'($urandom_range(0, 7));
      WbData        = $urandom;
      flush         = ($urandom % 16) == 0;
      #1;
      chk("rnd_in_ready", 64'(ifc.in_ready), 64'(!m_valid || ifc.out_ready));
      chk("rnd_RS2",      64'(RS2),          64'(ifc.in_rs2));
      step();
      chk("rnd_valid", 64'(ifc.out_valid), 64'(m_valid));
      chk("rnd_op1",   64'(ifc.out_op1),   64'(m_op1));
      chk("rnd_op2",   64'(ifc.out_op2),   64'(m_op2));
      chk("rnd_pc",    64'(ifc.out_pc),    64'(m_pc));
      chk("rnd_rd",    64'(ifc.out_rd),    64'(m_rd));
      chk("rnd_regwr", 64'(ifc.out_regwr), 64'(m_regwr));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
